flp_acc_seq: RTL and testbench

//  Sequential FP32 accumulator. Feeds operand pairs to the combinational FLP adder (instantiated by parent).

---
 rtl/flp_pkg.sv | 19 +
 rtl/flp_acc_seq_if.sv | 32 +++
 rtl/flp_acc_seq.sv | 107 ++++++++++
 tb/tb_flp_acc_seq.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/flp_pkg.sv
// Shared FP32 field widths, accumulator FSM state type and exponent helper.
package flp_pkg;

    localparam int FLP_W = 32;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // True for zero and denormal encodings (biased exponent field all zeros).
    function automatic logic is_zero_exp(input logic [FLP_W-1:0] x);
        return (x[FLP_W-2 -: EXP_W] == '0);
    endfunction

endpackage

// File: rtl/flp_acc_seq_if.sv
// Stream, result and external-adder signals of the FP32 accumulator.
interface flp_acc_seq_if
    import flp_pkg::*;
#(
    parameter int LEN_W = 8
);

    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic [FLP_W-1:0] in_data;
    logic             in_ready;
    logic [FLP_W-1:0] add_a;
    logic [FLP_W-1:0] add_b;
    logic [FLP_W-1:0] add_d;
    logic             out_valid;
    logic [FLP_W-1:0] out_data;
    logic             out_ready;
    logic             busy;

    // master: parent side that owns the stream, the consumer and the adder
    modport master (
        output start, len, in_valid, in_data, out_ready, add_d,
        input  in_ready, out_valid, out_data, busy, add_a, add_b
    );

    modport slave (
        input  start, len, in_valid, in_data, out_ready, add_d,
        output in_ready, out_valid, out_data, busy, add_a, add_b
    );

endinterface

// File: rtl/flp_acc_seq.sv
// Sequential FP32 accumulator around an external combinational adder.
// Optional macro FLP_ACC_ZERO_BYPASS_EN skips zero/denormal operands.
//
// state | meaning
// IDLE  | waiting for start; len latched on start
// ACCUM | accepting elements, one per cycle, acc folded through adder
// DONE  | sum held on out_data until out_ready
module flp_acc_seq
    import flp_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    flp_acc_seq_if.slave  bus
);

    state_t           state;
    logic [FLP_W-1:0] acc;
    logic [LEN_W-1:0] remaining;
    logic             first;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [FLP_W-1:0] out_data_q;
    logic [FLP_W-1:0] acc_next;
    logic             xfer;

    assign xfer          = bus.in_valid && in_ready_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = (state != IDLE);
    assign bus.add_a     = acc;
    assign bus.add_b     = (state == ACCUM) ? bus.in_data : '0;

    // The first element seeds acc directly so no clear-to-zero pass is needed.
    always_comb begin
        acc_next = bus.add_d;
        if (first) begin
            acc_next = bus.in_data;
        end else begin
`ifdef FLP_ACC_ZERO_BYPASS_EN
            if (is_zero_exp(bus.in_data)) begin
                acc_next = acc;
            end else if (is_zero_exp(acc)) begin
                acc_next = bus.in_data;
            end
`else
            acc_next = bus.add_d;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            remaining   <= '0;
            first       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.len != '0) begin
                            state      <= ACCUM;
                            remaining  <= bus.len;
                            first      <= 1'b1;
                            in_ready_q <= 1'b1;
                        end else begin
                            state       <= DONE;
                            out_data_q  <= '0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (xfer) begin
                        acc       <= acc_next;
                        first     <= 1'b0;
                        remaining <= remaining - 1'b1;
                        if (remaining == LEN_W'(1)) begin
                            state       <= DONE;
                            out_data_q  <= acc_next;
                            out_valid_q <= 1'b1;
                            in_ready_q  <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flp_acc_seq.sv
// Self-checking bench for flp_acc_seq with a behavioural FP32 adder on the add_* ports.
module tb_flp_acc_seq;
    import flp_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    flp_acc_seq_if #(.LEN_W(8)) bus();
    flp_acc_seq #(.LEN_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int errors = 0;
    int checks = 0;
    logic [31:0] stim_q[$];

    // Truncating FP32 adder for normal operands; zero/denormal inputs treated as zero.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] t;
        logic [7:0]  ea, eb, er;
        logic [26:0] ma, mb, mr;
        int          d;
        if (a[30:23] == 8'd0) return b;
        if (b[30:23] == 8'd0) return a;
        if (a[30:0] < b[30:0]) begin t = a; a = b; b = t; end
        ea = a[30:23]; eb = b[30:23];
        ma = {2'b01, a[22:0], 2'b00};
        mb = {2'b01, b[22:0], 2'b00};
        d  = int'(ea) - int'(eb);
        mb = (d > 26) ? 27'd0 : (mb >> d);
        er = ea;
        if (a[31] == b[31]) begin
            mr = ma + mb;
            if (mr[26]) begin mr = mr >> 1; er = er + 8'd1; end
        end else begin
            mr = ma - mb;
            if (mr == 27'd0) return 32'd0;
            for (int i = 0; i < 26; i++) begin
                if (!mr[25]) begin mr = mr << 1; er = er - 8'd1; end
            end
        end
        return {a[31], er, mr[24:2]};
    endfunction

    function automatic logic [31:0] int2fp(input int unsigned n);
        int p = 0;
        logic [31:0] m;
        if (n == 0) return 32'd0;
        for (int i = 0; i < 24; i++) if (n[i]) p = i;
        m = 32'(n) << (23 - p);
        return {1'b0, 8'(127 + p), m[22:0]};
    endfunction

    assign bus.add_d = fp_add(bus.add_a, bus.add_b);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a sum over stim_q and stops once out_valid is seen (or a budget expires).
    task automatic drive_sum(input int n, input int gap_pct, output logic [31:0] res,
                             output int lat, output bit timeout);
        int idx = 0;
        int budget;
        bit v, x;
        timeout = 1'b0; lat = 0; res = '0;
        bus.start = 1'b1; bus.len = 8'(n);
        tick();
        bus.start = 1'b0; bus.len = 8'($urandom);
        budget = n * 20 + 20;
        while (idx < n && budget > 0) begin
            v = ($urandom_range(99) >= gap_pct);
            bus.in_valid = v;
            bus.in_data  = v ? stim_q[idx] : 32'($urandom);
            x = v && bus.in_ready;
            tick();
            if (x) idx++;
            budget--;
        end
        bus.in_valid = 1'b0;
        if (idx < n) timeout = 1'b1;
        while (!bus.out_valid && lat < 5) begin tick(); lat++; end
        if (!bus.out_valid) timeout = 1'b1;
        res = bus.out_data;
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.start = 0; bus.len = 0; bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 0;
        rst_n = 1'b0;
        repeat (2) tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_data !== 32'd0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", bus.out_data); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.add_a !== 32'd0) begin errors++; $display("FAIL reset_add_a got=%h exp=0", bus.add_a); end
        checks++; if (bus.add_b !== 32'd0) begin errors++; $display("FAIL reset_add_b got=%h exp=0", bus.add_b); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [31:0] res; int lat; bit to;
        stim_q = '{32'h3F800000, 32'h40000000};
        drive_sum(2, 0, res, lat, to);
        checks++; if (to || lat != 0) begin errors++; $display("FAIL basic_latency got=%0d timeout=%0d exp=0", lat, to); end
        checks++; if (res !== 32'h40400000) begin errors++; $display("FAIL basic_sum got=%h exp=40400000", res); end
        checks++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL basic_done_flags got in_ready=%b busy=%b exp 0/1", bus.in_ready, bus.busy); end
        release_out();
        checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL basic_release got out_valid=%b busy=%b exp 0/0", bus.out_valid, bus.busy); end
    endtask

    task automatic test_gaps();
        logic [31:0] res; int lat; bit to;
        stim_q = '{32'h3F000000, 32'h3F000000, 32'h3F000000};
        drive_sum(3, 60, res, lat, to);
        checks++; if (to || lat != 0) begin errors++; $display("FAIL gaps_latency got=%0d timeout=%0d exp=0", lat, to); end
        checks++; if (res !== 32'h3FC00000) begin errors++; $display("FAIL gaps_sum got=%h exp=3FC00000", res); end
        release_out();
    endtask

    task automatic test_len_zero();
        bus.start = 1'b1; bus.len = 8'd0;
        tick();
        bus.start = 1'b0;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL len0_out_valid got=%b exp=1", bus.out_valid); end
        checks++; if (bus.out_data !== 32'd0) begin errors++; $display("FAIL len0_out_data got=%h exp=0", bus.out_data); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL len0_in_ready got=%b exp=0", bus.in_ready); end
        release_out();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL len0_release got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_hold();
        logic [31:0] res; int lat; bit to;
        stim_q = '{32'h3F800000, 32'h40000000};
        drive_sum(2, 0, res, lat, to);
        for (int c = 0; c < 5; c++) begin
            bus.start = (c == 1 || c == 2); bus.len = 8'd3;
            bus.in_valid = 1'b1; bus.in_data = 32'h41200000;
            tick();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h40400000) begin errors++; $display("FAIL hold_out c=%0d got valid=%b data=%h exp 1/40400000", c, bus.out_valid, bus.out_data); end
            checks++; if (bus.in_ready !== 1'b0 || bus.add_b !== 32'd0) begin errors++; $display("FAIL hold_in c=%0d got in_ready=%b add_b=%h exp 0/0", c, bus.in_ready, bus.add_b); end
        end
        bus.start = 1'b0; bus.in_valid = 1'b0;
        release_out();
        tick();
        checks++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL hold_idle got busy=%b in_ready=%b exp 0/0", bus.busy, bus.in_ready); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res; int lat; bit to;
        bus.start = 1'b1; bus.len = 8'd4;
        tick();
        bus.start = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 32'h3F800000;
        tick();
        bus.in_data = 32'h40000000;
        #1 rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 32'd0) begin errors++; $display("FAIL midrst_out got valid=%b data=%h exp 0/0", bus.out_valid, bus.out_data); end
        checks++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_flags got in_ready=%b busy=%b exp 0/0", bus.in_ready, bus.busy); end
        checks++; if (bus.add_a !== 32'd0 || bus.add_b !== 32'd0) begin errors++; $display("FAIL midrst_adder got a=%h b=%h exp 0/0", bus.add_a, bus.add_b); end
        bus.in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        stim_q = '{32'h40000000};
        drive_sum(1, 0, res, lat, to);
        checks++; if (to || res !== 32'h40000000) begin errors++; $display("FAIL midrst_resum got=%h timeout=%0d exp=40000000", res, to); end
        release_out();
    endtask

    task automatic test_zero_bypass();
        logic [31:0] res; int lat; bit to;
        stim_q = '{32'h00000000, 32'h3F800000};
        drive_sum(2, 0, res, lat, to);
        checks++; if (to || res !== 32'h3F800000) begin errors++; $display("FAIL zero_first got=%h timeout=%0d exp=3F800000", res, to); end
        release_out();
        stim_q = '{32'h3F800000, 32'h00000000, 32'h40000000};
        drive_sum(3, 20, res, lat, to);
        checks++; if (to || res !== 32'h40400000) begin errors++; $display("FAIL zero_mid got=%h timeout=%0d exp=40400000", res, to); end
        release_out();
    endtask

    task automatic test_random();
        logic [31:0] res; int lat; bit to;
        int n; int unsigned sum, v;
        for (int it = 0; it < 20; it++) begin
            n = $urandom_range(12, 1);
            sum = 0;
            stim_q.delete();
            for (int k = 0; k < n; k++) begin
                v = $urandom_range(100, 1);
                sum += v;
                stim_q.push_back(int2fp(v));
            end
            drive_sum(n, 30, res, lat, to);
            checks++; if (to || lat != 0) begin errors++; $display("FAIL rand_latency it=%0d got=%0d timeout=%0d exp=0", it, lat, to); end
            checks++; if (res !== int2fp(sum)) begin errors++; $display("FAIL rand_sum it=%0d n=%0d got=%h exp=%h", it, n, res, int2fp(sum)); end
            repeat ($urandom_range(2)) tick();
            release_out();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_len_zero();
        test_hold();
        test_reset_mid();
        test_zero_bypass();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
